// File: rtl/types_pkg.sv
// Shared types for the board front end and the datapath it drives.
//   word_t      : 16-bit operand / switch word
//   opr_mode_t  : operating mode shown on SELECTOR
//   btn_idx_t   : bit positions within the {C,U,D,L,R} button vectors
package types_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    RESET        = 3'd0,
    ADD          = 3'd1,
    SUB          = 3'd2,
    MUL          = 3'd3,
    COUNT_ONES   = 3'd4,
    LEADING_ONES = 3'd5
  } opr_mode_t;

  localparam int BTN_COUNT = 5;

  // Vectors are packed {C,U,D,L,R}, so C sits in the MSB.
  typedef enum logic [2:0] {
    BTN_C = 3'd4,
    BTN_U = 3'd3,
    BTN_D = 3'd2,
    BTN_L = 3'd1,
    BTN_R = 3'd0
  } btn_idx_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchronizer, stability counter and
// rising-edge detect on the debounced level.
//   clk, rst_n : clock, async active-low reset
//   raw        : raw asynchronous button pin
//   db         : debounced level (registered)
//   rise       : one-cycle pulse when db goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             db_prev;
  logic             s;

  assign s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      db      <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      db_prev <= db;
      // Any return to the accepted level restarts the count, so only a
      // level held for DEBOUNCE_CYCLES consecutive cycles is taken. The
      // equality compare keeps cnt from ever wrapping.
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = db & ~db_prev;

endmodule

// File: rtl/button_mode_ctrl.sv
// Board-side front end: debounces the five push-buttons, turns press edges
// into an operating mode and captures the slide switches as the operand.
//   clk, rst_n        : clock, async active-low reset
//   BTNC/U/D/L/R      : raw push-buttons
//   SW                : raw slide switches
//   SELECTOR, OPERAND : latched mode and operand, held until the next press
//   mode_chg          : one-cycle pulse when SELECTOR/OPERAND update
//   btn_db            : debounced levels {C,U,D,L,R}
module button_mode_ctrl
  import types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 BTNC,
  input  logic                 BTNU,
  input  logic                 BTND,
  input  logic                 BTNL,
  input  logic                 BTNR,
  input  word_t                SW,
  output opr_mode_t            SELECTOR,
  output word_t                OPERAND,
  output logic                 mode_chg,
  output logic [BTN_COUNT-1:0] btn_db
);

  logic [BTN_COUNT-1:0] btn_raw;
  logic [BTN_COUNT-1:0] press;
  word_t                sw_s1, sw_s2;
  opr_mode_t            mode_nxt;
  logic                 upd;

  assign btn_raw = {BTNC, BTNU, BTND, BTNL, BTNR};

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .db   (btn_db[i]),
      .rise (press[i])
    );
  end

  // Only edges count: a held button never re-triggers, but a new edge on a
  // lower-priority button while another is held still wins that cycle.
  always_comb begin
    upd      = |press;
    mode_nxt = SELECTOR;
    if      (press[BTN_C]) mode_nxt = MUL;
    else if (press[BTN_U]) mode_nxt = LEADING_ONES;
    else if (press[BTN_D]) mode_nxt = COUNT_ONES;
    else if (press[BTN_L]) mode_nxt = ADD;
    else if (press[BTN_R]) mode_nxt = SUB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      SELECTOR <= RESET;
      OPERAND  <= '0;
      mode_chg <= 1'b0;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      mode_chg <= upd;
      if (upd) begin
        SELECTOR <= mode_nxt;
        OPERAND  <= sw_s2;
      end
    end
  end

endmodule
